// File: rtl/dbg_ctrl_pkg.sv
// Shared types and defaults for the debug halt handshake.
// Imported by the halt controller and its counter.
package dbg_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } dbg_state_e;

    localparam int DBG_TIMEOUT = 16;
    localparam int DBG_TO_W    = 5;
    localparam int DBG_STEP_W  = 8;

endpackage

// File: rtl/dbg_step_cnt.sv
// Saturating counter with a terminal flag.
// Down mode stops at 1 (last at 1); up mode stops at LIMIT-1.
module dbg_step_cnt
    import dbg_ctrl_pkg::*;
#(
    parameter int W     = DBG_STEP_W,
    parameter bit UP    = 1'b0,
    parameter int LIMIT = 1
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         last
);

    logic [W-1:0] cnt;
    logic         sat;

    // terminal value and saturation point for the selected direction
    always_comb begin
        last = 1'b0;
        sat  = 1'b0;
        if (UP) begin
            last = (cnt == W'(LIMIT - 1));
            sat  = last;
        end else begin
            last = (cnt == W'(1));
            sat  = (cnt <= W'(1));
        end
    end

    // load on entry, otherwise count until saturated
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= UP ? '0 : load_val;
        end else if (en && !sat) begin
            cnt <= UP ? cnt + W'(1) : cnt - W'(1);
        end
    end

endmodule

// File: rtl/dbg_halt_ctrl.sv
// Debug-side halt request FSM with N-tick stepping.
// Drives halt_req to counter control, tracks halt_ack.
module dbg_halt_ctrl
    import dbg_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DBG_TIMEOUT,
    parameter int TO_W    = DBG_TO_W,
    parameter int STEP_W  = DBG_STEP_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              dbg_mode,
    input  logic              halt_cmd,
    input  logic              resume_cmd,
    input  logic              step_cmd,
    input  logic [STEP_W-1:0] step_val,
    input  logic              err_clr,
    input  logic              halt_ack,
    input  logic              cnt_en,
    output logic              halt_req,
    output logic              halted,
    output logic              busy,
    output logic              step_done,
    output logic              timeout_err,
    output logic              halt_lost
);

    dbg_state_e state_q, state_d;
    logic       step_flag_q, step_flag_d;
    logic       step_done_d;
    logic       to_set, lost_set;
    logic       ack_ok;
    logic       to_load, to_en, to_last;
    logic       st_load, st_en, st_last;

    assign ack_ok  = halt_ack & dbg_mode;
    assign to_load = (state_d == REQ) && (state_q != REQ);
    assign to_en   = (state_q == REQ) && !ack_ok;
    assign st_en   = (state_q == STEP) && cnt_en;

    dbg_step_cnt #(
        .W     (TO_W),
        .UP    (1'b1),
        .LIMIT (TIMEOUT)
    ) u_to_cnt (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (to_load),
        .load_val ('0),
        .en       (to_en),
        .last     (to_last)
    );

    dbg_step_cnt #(
        .W     (STEP_W),
        .UP    (1'b0),
        .LIMIT (1)
    ) u_step_cnt (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (st_load),
        .load_val (step_val),
        .en       (st_en),
        .last     (st_last)
    );

    // next state, step bookkeeping and error set conditions
    always_comb begin
        state_d     = state_q;
        step_flag_d = step_flag_q;
        step_done_d = 1'b0;
        to_set      = 1'b0;
        lost_set    = 1'b0;
        st_load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (halt_cmd) begin
                    state_d     = REQ;
                    step_flag_d = 1'b0;
                end
            end
            REQ: begin
                if (resume_cmd) begin
                    state_d = IDLE;
                end else if (ack_ok) begin
                    state_d     = HALTED;
                    step_done_d = step_flag_q;
                end else if (to_last) begin
                    state_d = IDLE;
                    to_set  = 1'b1;
                end
            end
            HALTED: begin
                if (!ack_ok) begin
                    state_d  = IDLE;
                    lost_set = 1'b1;
                end else if (resume_cmd) begin
                    state_d = IDLE;
                end else if (halt_cmd) begin
                    state_d = HALTED;
                end else if (step_cmd) begin
                    if (step_val != '0) begin
                        state_d = STEP;
                        st_load = 1'b1;
                    end else begin
                        step_done_d = 1'b1;
                    end
                end
            end
            STEP: begin
                if (resume_cmd) begin
                    state_d = IDLE;
                end else if (halt_cmd) begin
                    state_d     = REQ;
                    step_flag_d = 1'b0;
                end else if (cnt_en && st_last) begin
                    state_d     = REQ;
                    step_flag_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, registered outputs and sticky error flags
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            step_flag_q <= 1'b0;
            halt_req    <= 1'b0;
            halted      <= 1'b0;
            busy        <= 1'b0;
            step_done   <= 1'b0;
            timeout_err <= 1'b0;
            halt_lost   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_flag_q <= step_flag_d;
            halt_req    <= (state_d == REQ) || (state_d == HALTED);
            halted      <= (state_d == HALTED);
            busy        <= (state_d == REQ) || (state_d == STEP);
            step_done   <= step_done_d;
            timeout_err <= to_set | (timeout_err & ~err_clr);
            halt_lost   <= lost_set | (halt_lost & ~err_clr);
        end
    end

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Scoreboard bench for dbg_halt_ctrl with a modelled counter control.
// Expected output changes are queued with the cycle they must appear.
module tb_dbg_halt_ctrl;

    typedef struct {
        string      name;
        logic [5:0] vec;
        int         cyc;
    } exp_t;

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_REQ   = 6'b101000;
    localparam logic [5:0] O_HALT  = 6'b110000;
    localparam logic [5:0] O_HDONE = 6'b110100;
    localparam logic [5:0] O_STEP  = 6'b001000;
    localparam logic [5:0] O_TO    = 6'b000010;
    localparam logic [5:0] O_LOST  = 6'b000001;

    logic       sys_clk    = 1'b0;
    logic       sys_rst    = 1'b1;
    logic       dbg_mode   = 1'b1;
    logic       halt_cmd   = 1'b0;
    logic       resume_cmd = 1'b0;
    logic       step_cmd   = 1'b0;
    logic [7:0] step_val   = 8'd0;
    logic       err_clr    = 1'b0;
    logic       div_mode   = 1'b0;
    logic       halt_ack, cnt_en;
    logic       halt_req, halted, busy, step_done, timeout_err, halt_lost;

    int   cyc     = 0;
    int   n_ticks = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_on  = 1'b0;
    exp_t sbq[$];

    dbg_halt_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .dbg_mode    (dbg_mode),
        .halt_cmd    (halt_cmd),
        .resume_cmd  (resume_cmd),
        .step_cmd    (step_cmd),
        .step_val    (step_val),
        .err_clr     (err_clr),
        .halt_ack    (halt_ack),
        .cnt_en      (cnt_en),
        .halt_req    (halt_req),
        .halted      (halted),
        .busy        (busy),
        .step_done   (step_done),
        .timeout_err (timeout_err),
        .halt_lost   (halt_lost)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // counter control model: ack follows request in debug mode,
    // ticks every cycle or every 4th cycle, gated while acked
    assign halt_ack = halt_req & dbg_mode;
    assign cnt_en   = ~halt_ack & (~div_mode | (cyc[1:0] == 2'b11));

    always @(posedge sys_clk) if (cnt_en) n_ticks <= n_ticks + 1;

    task automatic exp_out(input string nm, input logic [5:0] v,
                           input int c);
        exp_t e;
        e.name = nm;
        e.vec  = v;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    task automatic cmd(input bit h, input bit r, input bit s,
                       input logic [7:0] v, input bit e);
        halt_cmd   = h;
        resume_cmd = r;
        step_cmd   = s;
        step_val   = v;
        err_clr    = e;
        @(negedge sys_clk);
        halt_cmd   = 1'b0;
        resume_cmd = 1'b0;
        step_cmd   = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        while (sbq.size() != 0 && b < budget) begin
            @(negedge sys_clk);
            b++;
        end
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_%s: nothing by cyc %0d, want out=%b at cyc %0d",
                     sbq[0].name, cyc, sbq[0].vec, sbq[0].cyc);
            sbq.delete();
        end
    endtask

    task automatic check_ticks(input string nm, input int got,
                               input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: ticks=%0d, want %0d", nm, got, want);
        end
    endtask

    // monitor: every change of the output vector pops one expectation
    initial begin
        logic [5:0] prev;
        logic [5:0] vec;
        exp_t       e;
        prev = 6'b111111;
        forever begin
            @(negedge sys_clk);
            if (mon_on) begin
                vec = {halt_req, halted, busy, step_done,
                       timeout_err, halt_lost};
                if (vec !== prev) begin
                    n_tests++;
                    if (sbq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected: out=%b at cyc %0d, want %b held",
                                 vec, cyc, prev);
                    end else begin
                        e = sbq.pop_front();
                        if (vec !== e.vec ||
                            (e.cyc >= 0 && cyc != e.cyc)) begin
                            n_fail++;
                            $display("FAIL %s: out=%b at cyc %0d, want %b at cyc %0d",
                                     e.name, vec, cyc, e.vec, e.cyc);
                        end
                    end
                    prev = vec;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: cyc=%0d, want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k0;

        exp_out("reset", O_IDLE, -1);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        mon_on  = 1'b1;
        drain(5);

        // basic halt handshake
        t = cyc;
        exp_out("halt_req", O_REQ, t + 1);
        exp_out("halted", O_HALT, t + 2);
        cmd(1, 0, 0, 8'd0, 0);
        drain(10);

        // zero-length step stays halted
        t = cyc;
        exp_out("step0_done", O_HDONE, t + 1);
        exp_out("step0_clr", O_HALT, t + 2);
        cmd(0, 0, 1, 8'd0, 0);
        drain(10);

        // step 3, undivided
        k0 = n_ticks;
        t  = cyc;
        exp_out("step3_run", O_STEP, t + 1);
        exp_out("step3_req", O_REQ, t + 4);
        exp_out("step3_done", O_HDONE, t + 5);
        exp_out("step3_halt", O_HALT, t + 6);
        cmd(0, 0, 1, 8'd3, 0);
        drain(20);
        check_ticks("step3_ticks", n_ticks - k0, 3);

        // step 2, tick every 4th cycle
        div_mode = 1'b1;
        while (cyc % 4 != 0) @(negedge sys_clk);
        k0 = n_ticks;
        t  = cyc;
        exp_out("div_run", O_STEP, t + 1);
        exp_out("div_req", O_REQ, t + 8);
        exp_out("div_done", O_HDONE, t + 9);
        exp_out("div_halt", O_HALT, t + 10);
        cmd(0, 0, 1, 8'd2, 0);
        drain(30);
        check_ticks("div_ticks", n_ticks - k0, 2);
        div_mode = 1'b0;

        // debug mode drops while halted
        t = cyc;
        exp_out("lost", O_LOST, t + 1);
        dbg_mode = 1'b0;
        @(negedge sys_clk);
        drain(5);
        t = cyc;
        exp_out("lost_clr", O_IDLE, t + 1);
        cmd(0, 0, 0, 8'd0, 1);
        drain(5);

        // timeout: request high exactly 16 cycles, set beats clear
        t = cyc;
        exp_out("to_req", O_REQ, t + 1);
        exp_out("to_err", O_TO, t + 17);
        cmd(1, 0, 0, 8'd0, 0);
        repeat (15) @(negedge sys_clk);
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        drain(10);

        // idle ignores resume and step; error stays sticky
        cmd(0, 1, 0, 8'd0, 0);
        cmd(0, 0, 1, 8'd4, 0);
        repeat (3) @(negedge sys_clk);
        t = cyc;
        exp_out("to_clr", O_IDLE, t + 1);
        cmd(0, 0, 0, 8'd0, 1);
        drain(5);

        // resume cancels a pending request without error
        t = cyc;
        exp_out("rq_req", O_REQ, t + 1);
        exp_out("rq_cancel", O_IDLE, t + 2);
        cmd(1, 0, 0, 8'd0, 0);
        cmd(0, 1, 0, 8'd0, 0);
        drain(10);
        repeat (20) @(negedge sys_clk);

        // reset in the middle of a step
        dbg_mode = 1'b1;
        t = cyc;
        exp_out("r_req", O_REQ, t + 1);
        exp_out("r_halt", O_HALT, t + 2);
        cmd(1, 0, 0, 8'd0, 0);
        drain(10);
        t = cyc;
        exp_out("r_run", O_STEP, t + 1);
        exp_out("rst_mid", O_IDLE, t + 5);
        cmd(0, 0, 1, 8'd8, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        drain(5);

        // after reset a fresh step grants exactly its own count
        t = cyc;
        exp_out("p_req", O_REQ, t + 1);
        exp_out("p_halt", O_HALT, t + 2);
        cmd(1, 0, 0, 8'd0, 0);
        drain(10);
        k0 = n_ticks;
        t  = cyc;
        exp_out("p_run", O_STEP, t + 1);
        exp_out("p_req2", O_REQ, t + 3);
        exp_out("p_done", O_HDONE, t + 4);
        exp_out("p_halt2", O_HALT, t + 5);
        cmd(0, 0, 1, 8'd2, 0);
        drain(20);
        check_ticks("p_ticks", n_ticks - k0, 2);

        // halt and resume together in step: resume wins
        t = cyc;
        exp_out("hr_run", O_STEP, t + 1);
        exp_out("hr_idle", O_IDLE, t + 2);
        cmd(0, 0, 1, 8'd5, 0);
        cmd(1, 1, 0, 8'd0, 0);
        drain(10);

        // halt aborts a step with no step_done
        t = cyc;
        exp_out("ab_req", O_REQ, t + 1);
        exp_out("ab_halt", O_HALT, t + 2);
        cmd(1, 0, 0, 8'd0, 0);
        drain(10);
        t = cyc;
        exp_out("ab_run", O_STEP, t + 1);
        exp_out("ab_req2", O_REQ, t + 2);
        exp_out("ab_halt2", O_HALT, t + 3);
        cmd(0, 0, 1, 8'd5, 0);
        cmd(1, 0, 0, 8'd0, 0);
        drain(10);
        repeat (3) @(negedge sys_clk);

        // resume from halted
        t = cyc;
        exp_out("res_idle", O_IDLE, t + 1);
        cmd(0, 1, 0, 8'd0, 0);
        drain(5);
        repeat (4) @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
